// File: rtl/bcd_to_binary_seq_pkg.sv
// Shared constants for the iterative BCD-to-binary converter: FSM encodings,
// BCD digit limits and the reverse double-dabble correction values.
package bcd_to_binary_seq_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CONV = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  localparam int         BCD_DIGIT_W   = 4;
  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;
  localparam logic [3:0] CORR_THRESH   = 4'd8;
  localparam logic [3:0] CORR_SUB      = 4'd3;

  function automatic logic digit_invalid(input logic [3:0] d);
    return d > BCD_MAX_DIGIT;
  endfunction

endpackage

// File: rtl/bcd_to_binary_seq_if.sv
// Start/busy/done handshake and data bus between operand entry and the converter.
interface bcd_to_binary_seq_if #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
);
  logic                  start;
  logic [4*DIGITS-1:0]   bcd_in;
  logic                  busy;
  logic                  done;
  logic [BIN_W-1:0]      binary_out;
  logic                  err;
  logic                  ovf;

  modport master (
    output start, bcd_in,
    input  busy, done, binary_out, err, ovf
  );

  modport slave (
    input  start, bcd_in,
    output busy, done, binary_out, err, ovf
  );
endinterface

// File: rtl/bcd_digit_sub3.sv
// One reverse double-dabble correction cell: subtract 3 from a BCD digit that is >= 8.
module bcd_digit_sub3
  import bcd_to_binary_seq_pkg::*;
(
  input  logic [3:0] d_in,
  output logic [3:0] d_out
);

  // A digit >= 8 can never borrow when reduced by 3.
  assign d_out = (d_in >= CORR_THRESH) ? (d_in - CORR_SUB) : d_in;

endmodule

// File: rtl/bcd_to_binary_seq.sv
// Iterative BCD-to-binary converter, one shift/correct step per clock.
// Optional build macro RANGE_CHECK_EN adds the ovf comparison against MAX_VALUE.
module bcd_to_binary_seq
  import bcd_to_binary_seq_pkg::*;
#(
  parameter int          DIGITS    = 4,
  parameter int          BIN_W     = 14,
  parameter int unsigned MAX_VALUE = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  bcd_to_binary_seq_if.slave   bus
);

  localparam int BCD_W = DIGITS * BCD_DIGIT_W;
  localparam int CAT_W = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);

  // Catch parameter sets that cannot hold the largest decimal input or MAX_VALUE.
  if ((2 ** BIN_W) <= (10 ** DIGITS) - 1) begin : g_chk_width
    $error("BIN_W too small for DIGITS");
  end
  if (MAX_VALUE >= (2 ** BIN_W)) begin : g_chk_max
    $error("MAX_VALUE not representable in BIN_W bits");
  end

  logic [1:0]       state_q,  state_d;
  logic [BCD_W-1:0] bcd_q,    bcd_d;
  logic [BIN_W-1:0] bin_q,    bin_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;
  logic [BIN_W-1:0] result_q, result_d;
  logic             err_q,    err_d;
  logic             ovf_q,    ovf_d;

  logic [CAT_W-1:0] cat_shift;
  logic [BCD_W-1:0] bcd_shift;
  logic [BCD_W-1:0] bcd_corr;
  logic [BIN_W-1:0] bin_shift;
  logic             any_bad;
  logic             ovf_calc;

  // {bcd, bin} shifts right as one register; the digits are then corrected in parallel.
  assign cat_shift = {bcd_q, bin_q} >> 1;
  assign bcd_shift = cat_shift[CAT_W-1:BIN_W];
  assign bin_shift = cat_shift[BIN_W-1:0];

  for (genvar g = 0; g < DIGITS; g++) begin : g_corr
    bcd_digit_sub3 u_sub3 (
      .d_in  (bcd_shift[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .d_out (bcd_corr[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  always_comb begin
    any_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      any_bad = any_bad | digit_invalid(bus.bcd_in[i*BCD_DIGIT_W +: BCD_DIGIT_W]);
    end
  end

`ifdef RANGE_CHECK_EN
  assign ovf_calc = 32'(bin_shift) > MAX_VALUE;
`else
  assign ovf_calc = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    bcd_d    = bcd_q;
    bin_d    = bin_q;
    cnt_d    = cnt_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    result_d = result_q;
    err_d    = err_q;
    ovf_d    = ovf_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          bcd_d = bus.bcd_in;
          bin_d = '0;
          cnt_d = '0;
          if (any_bad) begin
            state_d  = ST_FIN;
            done_d   = 1'b1;
            result_d = '0;
            err_d    = 1'b1;
            ovf_d    = 1'b0;
          end else begin
            state_d = ST_CONV;
            busy_d  = 1'b1;
          end
        end
      end
      ST_CONV: begin
        bcd_d = bcd_corr;
        bin_d = bin_shift;
        cnt_d = cnt_q + CNT_W'(1);
        // The final step's shifted value is the result latched on entry to FIN.
        if (cnt_q == CNT_W'(BIN_W - 1)) begin
          state_d  = ST_FIN;
          done_d   = 1'b1;
          result_d = bin_shift;
          err_d    = 1'b0;
          ovf_d    = ovf_calc;
        end else begin
          busy_d = 1'b1;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      bcd_q    <= '0;
      bin_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      bcd_q    <= bcd_d;
      bin_q    <= bin_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      err_q    <= err_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.binary_out = result_q;
  assign bus.err        = err_q;
  assign bus.ovf        = ovf_q;

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Scoreboard bench for bcd_to_binary_seq: decimal reference model, directed and random vectors.
module tb_bcd_to_binary_seq;

  localparam int DIGITS = 4;
  localparam int BIN_W  = 14;
  localparam int MAXV   = 255;

`ifdef RANGE_CHECK_EN
  localparam bit RANGE = 1'b1;
`else
  localparam bit RANGE = 1'b0;
`endif

  typedef struct {
    int unsigned value;
    bit          err;
    bit          ovf;
    int          lat;
    int          issue;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   total;
  int   bad;
  exp_t sb[$];
  int unsigned held_bin;
  bit   held_err;
  bit   held_ovf;

  bcd_to_binary_seq_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) bus ();

  bcd_to_binary_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W), .MAX_VALUE(MAXV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: decimal digit weighting, independent of any shift/correct procedure.
  function automatic exp_t model(input logic [15:0] b, input int issue);
    exp_t r;
    int unsigned v;
    bit e;
    logic [3:0] d;
    v = 0;
    e = 0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      d = b[i*4 +: 4];
      if (d > 9) e = 1;
      v = v * 10 + d;
    end
    r.value = e ? 0 : v;
    r.err   = e;
    r.ovf   = RANGE && !e && (v > MAXV);
    r.lat   = e ? 1 : BIN_W + 1;
    r.issue = issue;
    return r;
  endfunction

  // Monitor: pops on every done pulse, otherwise checks that results are held.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (bus.done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("binary_out", bus.binary_out, e.value);
          chk("err", bus.err, e.err);
          chk("ovf", bus.ovf, e.ovf);
          chk("latency", cyc - e.issue, e.lat);
          chk("busy_at_done", bus.busy, 0);
          held_bin = e.value;
          held_err = e.err;
          held_ovf = e.ovf;
        end
      end else begin
        chk("held_binary_out", bus.binary_out, held_bin);
        chk("held_err", bus.err, held_err);
        chk("held_ovf", bus.ovf, held_ovf);
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while ((bus.busy || bus.done) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("idle_timeout", n, 0);
  endtask

  // Called at a negedge; pulses start for one edge.
  task automatic issue(input logic [15:0] b, input bit push);
    exp_t e;
    wait_idle();
    e = model(b, cyc);
    bus.start  = 1'b1;
    bus.bcd_in = b;
    if (push) sb.push_back(e);
    @(negedge clk);
    bus.start  = 1'b0;
    bus.bcd_in = 16'($urandom);
    if (e.err) chk("busy_on_err", bus.busy, 0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", sb.size(), 0);
    @(negedge clk);
  endtask

  function automatic logic [15:0] rand_bcd();
    logic [15:0] b;
    for (int i = 0; i < DIGITS; i++) begin
      if ($urandom_range(0, 7) == 0) b[i*4 +: 4] = 4'($urandom_range(10, 15));
      else                           b[i*4 +: 4] = 4'($urandom_range(0, 9));
    end
    return b;
  endfunction

  initial begin
    logic [15:0] dir [6];
    total    = 0;
    bad      = 0;
    held_bin = 0;
    held_err = 0;
    held_ovf = 0;
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.bcd_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_binary_out", bus.binary_out, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_ovf", bus.ovf, 0);
    rst = 1'b0;
    @(negedge clk);

    dir = '{16'h9999, 16'h0000, 16'h0255, 16'h0256, 16'h12A4, 16'h0001};
    foreach (dir[i]) issue(dir[i], 1'b1);
    drain();

    // Starts during CONV and during the FIN cycle must be ignored.
    issue(16'h0042, 1'b1);
    repeat (3) @(negedge clk);
    bus.start = 1'b1; bus.bcd_in = 16'h0999;
    @(negedge clk);
    bus.start = 1'b0;
    begin
      int n;
      n = 0;
      while (!bus.done && n < 40) begin @(negedge clk); n++; end
      chk("done_seen_0042", bus.done, 1);
    end
    bus.start = 1'b1; bus.bcd_in = 16'h0999;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (25) @(negedge clk);
    chk("no_second_done", sb.size(), 0);

    // Asynchronous reset in the middle of a conversion.
    issue(16'h5000, 1'b0);
    repeat (6) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    held_bin = 0; held_err = 0; held_ovf = 0;
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_binary_out", bus.binary_out, 0);
    chk("abort_err", bus.err, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    issue(16'h5000, 1'b1);
    drain();

    // Start held high: one accepted conversion every BIN_W+2 cycles.
    wait_idle();
    bus.start  = 1'b1;
    bus.bcd_in = 16'h0123;
    for (int k = 0; k < 3; k++) sb.push_back(model(16'h0123, cyc + k * (BIN_W + 2)));
    repeat (2 * (BIN_W + 2) + 1) @(negedge clk);
    bus.start = 1'b0;
    drain();

    for (int i = 0; i < 24; i++) issue(rand_bcd(), 1'b1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
